lut_divider_2b_seq: RTL and testbench

LUT_DIVIDER_2B_SEQ -- requirements
Module: lut_divider_2b_seq

---
 rtl/lut_divider_2b_seq.sv | 158 +++++++++++++++
 tb/tb_lut_divider_2b_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_divider_2b_seq.sv
// Sequential radix-4 unsigned divider: two quotient bits per cycle, digit chosen by
// comparing the partial remainder against a small table of divisor multiples.
module lut_divider_2b_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_div_2b,
    input  logic             resetn_div_2b,
    input  logic             start_div_2b,
    input  logic [WIDTH-1:0] dividend_div_2b,
    input  logic [WIDTH-1:0] divisor_div_2b,
    output logic             busy_div_2b,
    output logic             done_div_2b,
    output logic [WIDTH-1:0] quotient_div_2b,
    output logic [WIDTH-1:0] remainder_div_2b,
    output logic             div_zero_div_2b
);

    localparam int RW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH / 2 + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH / 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] wq_q, wq_d;
    logic [RW-1:0]    wr_q, wr_d;
    logic [RW-1:0]    m1_q, m1_d, m2_q, m2_d, m3_q, m3_d;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
    logic             dz_q, dz_d, done_q, done_d;

    logic [RW-1:0]    trial, msel, r_next;
    logic [1:0]       digit;
    logic [WIDTH-1:0] q_next;

    function automatic logic [1:0] radix4_digit(input logic [RW-1:0] t,
                                                input logic [RW-1:0] m1,
                                                input logic [RW-1:0] m2,
                                                input logic [RW-1:0] m3);
        logic [1:0] d;
        if (t >= m3)      d = 2'd3;
        else if (t >= m2) d = 2'd2;
        else if (t >= m1) d = 2'd1;
        else              d = 2'd0;
        return d;
    endfunction

    // Remainder stays below the divisor, so only its low WIDTH bits feed the next trial.
    always_comb begin
        trial = RW'({wr_q, wq_q[WIDTH-1:WIDTH-2]});
        digit = radix4_digit(trial, m1_q, m2_q, m3_q);
        case (digit)
            2'd3:    msel = m3_q;
            2'd2:    msel = m2_q;
            2'd1:    msel = m1_q;
            default: msel = '0;
        endcase
        r_next = trial - msel;
        q_next = {wq_q[WIDTH-3:0], digit};
    end

    always_ff @(posedge clk_div_2b or negedge resetn_div_2b) begin
        if (!resetn_div_2b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_div_2b && (divisor_div_2b != '0)) state_d = RUN;
            RUN:     if (cnt_q == CNT_ONE) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wq_d   = wq_q;
        wr_d   = wr_q;
        m1_d   = m1_q;
        m2_d   = m2_q;
        m3_d   = m3_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dz_d   = dz_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_div_2b) begin
                    if (divisor_div_2b == '0) begin
                        quot_d = '1;
                        rem_d  = dividend_div_2b;
                        dz_d   = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        wq_d  = dividend_div_2b;
                        wr_d  = '0;
                        m1_d  = {2'b00, divisor_div_2b};
                        m2_d  = {1'b0, divisor_div_2b, 1'b0};
                        m3_d  = {1'b0, divisor_div_2b, 1'b0} + {2'b00, divisor_div_2b};
                        cnt_d = CNT_LOAD;
                    end
                end
            end
            RUN: begin
                wr_d  = r_next;
                wq_d  = q_next;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    quot_d = q_next;
                    rem_d  = r_next[WIDTH-1:0];
                    dz_d   = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_div_2b or negedge resetn_div_2b) begin
        if (!resetn_div_2b) begin
            cnt_q  <= '0;
            wq_q   <= '0;
            wr_q   <= '0;
            m1_q   <= '0;
            m2_q   <= '0;
            m3_q   <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wq_q   <= wq_d;
            wr_q   <= wr_d;
            m1_q   <= m1_d;
            m2_q   <= m2_d;
            m3_q   <= m3_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dz_q   <= dz_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        busy_div_2b      = (state_q == RUN);
        done_div_2b      = done_q;
        quotient_div_2b  = quot_q;
        remainder_div_2b = rem_q;
        div_zero_div_2b  = dz_q;
    end

endmodule

// File: tb/tb_lut_divider_2b_seq.sv
// Bench for lut_divider_2b_seq: directed vector table, control corner sequences,
// and random operands on a 32-bit and an 8-bit instance against plain / and %.
module tb_lut_divider_2b_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [31:0] dd, dv;
    logic        busy, done, dz;
    logic [31:0] quo, rem;

    logic        s_start;
    logic [7:0]  s_dd, s_dv;
    logic        s_busy, s_done, s_dz;
    logic [7:0]  s_quo, s_rem;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lut_divider_2b_seq #(.WIDTH(32)) dut (
        .clk_div_2b(clk), .resetn_div_2b(resetn), .start_div_2b(start),
        .dividend_div_2b(dd), .divisor_div_2b(dv),
        .busy_div_2b(busy), .done_div_2b(done),
        .quotient_div_2b(quo), .remainder_div_2b(rem), .div_zero_div_2b(dz)
    );

    lut_divider_2b_seq #(.WIDTH(8)) dut8 (
        .clk_div_2b(clk), .resetn_div_2b(resetn), .start_div_2b(s_start),
        .dividend_div_2b(s_dd), .divisor_div_2b(s_dv),
        .busy_div_2b(s_busy), .done_div_2b(s_done),
        .quotient_div_2b(s_quo), .remainder_div_2b(s_rem), .div_zero_div_2b(s_dz)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Start at the next falling edge; lat counts rising edges after the accepting edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r, output logic z,
                          output int lat, output int bc, output logic bd);
        @(negedge clk);
        start = 1'b1;
        dd    = a;
        dv    = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        bc    = 0;
        while (!done && lat < 40) begin
            if (busy) bc++;
            @(posedge clk); #1;
            lat++;
        end
        q  = quo;
        r  = rem;
        z  = dz;
        bd = busy;
    endtask

    task automatic random32(input int n);
        logic [31:0] a, b, q, r, eq, er;
        logic        z, ez, bd;
        int          lat, bc, el, mode;
        for (int i = 0; i < n; i++) begin
            mode = $urandom_range(0, 9);
            a    = $urandom;
            case (mode)
                0: b = 32'd1;
                1: begin
                    b = $urandom;
                    if (b == 0) b = 32'd1;
                    a = a % b;
                end
                2: b = 32'd0;
                3: b = $urandom_range(1, 15);
                default: begin
                    b = $urandom >> $urandom_range(0, 31);
                    if (b == 0) b = 32'd1;
                end
            endcase
            if (b == 0) begin
                eq = '1; er = a; ez = 1'b1; el = 0;
            end else begin
                eq = a / b; er = a % b; ez = 1'b0; el = 16;
            end
            run_op(a, b, q, r, z, lat, bc, bd);
            chk("rnd32_q", q, eq);
            chk("rnd32_r", r, er);
            chk("rnd32_dz", z, ez);
            chk("rnd32_lat", lat, el);
            if (b != 0)
                chk("rnd32_ident", ((64'(q) * 64'(b) + 64'(r)) == 64'(a)) && (r < b), 1);
        end
    endtask

    task automatic random8(input int n);
        logic [7:0] a, b, eq, er;
        logic       ez;
        int         lat, el;
        for (int i = 0; i < n; i++) begin
            a = 8'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 8'd0;
                1:       b = 8'd1;
                default: b = 8'($urandom);
            endcase
            if (b == 0) begin
                eq = '1; er = a; ez = 1'b1; el = 0;
            end else begin
                eq = a / b; er = a % b; ez = 1'b0; el = 4;
            end
            @(negedge clk);
            s_start = 1'b1;
            s_dd    = a;
            s_dv    = b;
            @(posedge clk); #1;
            s_start = 1'b0;
            lat     = 0;
            while (!s_done && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            chk("rnd8_q", s_quo, eq);
            chk("rnd8_r", s_rem, er);
            chk("rnd8_dz", s_dz, ez);
            chk("rnd8_lat", lat, el);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q, r;
        logic        z, bd;
        int          lat, bc, n, seen;

        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 16};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 16};
        vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 16};
        vecs[3] = '{32'd5,          32'd10,         32'd0,          32'd5,          1'b0, 16};
        vecs[4] = '{32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 0};
        vecs[5] = '{32'd1000,       32'd33,         32'd30,         32'd10,         1'b0, 16};
        vecs[6] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 16};
        vecs[7] = '{32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFE,  1'b0, 16};
        vecs[8] = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,          1'b0, 16};

        resetn = 1'b0; start = 1'b0; dd = '0; dv = '0;
        s_start = 1'b0; s_dd = '0; s_dv = '0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quo", quo, 0);
        chk("rst_rem", rem, 0);
        chk("rst_dz", dz, 0);
        chk("rst8_done", s_done, 0);
        @(posedge clk); #3;
        resetn = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, q, r, z, lat, bc, bd);
            chk($sformatf("vec%0d_q", i), q, vecs[i].q);
            chk($sformatf("vec%0d_r", i), r, vecs[i].r);
            chk($sformatf("vec%0d_dz", i), z, vecs[i].z);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_busycyc", i), bc, vecs[i].lat);
            chk($sformatf("vec%0d_busy_at_done", i), bd, 0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_pulse", i), done, 0);
            chk($sformatf("vec%0d_hold_q", i), quo, vecs[i].q);
        end

        // Start during RUN is ignored; start in the done cycle is accepted.
        @(negedge clk);
        dd = 32'd100; dv = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        repeat (4) begin @(posedge clk); #1; n++; end
        start = 1'b1; dd = 32'd9; dv = 32'd3;
        @(posedge clk); #1;
        n++;
        start = 1'b0;
        while (!done && n < 40) begin @(posedge clk); #1; n++; end
        chk("ign_lat", n, 16);
        chk("ign_q", quo, 14);
        chk("ign_r", rem, 2);
        chk("ign_dz", dz, 0);
        start = 1'b1; dd = 32'd9; dv = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        chk("b2b_done_drop", done, 0);
        chk("b2b_busy", busy, 1);
        chk("b2b_hold_q", quo, 14);
        while (!done && n < 40) begin @(posedge clk); #1; n++; end
        chk("b2b_lat", n, 16);
        chk("b2b_q", quo, 3);
        chk("b2b_r", rem, 0);

        // Reset in RUN cycle 8 aborts the operation.
        @(negedge clk);
        dd = 32'd100; dv = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        chk("pre_rst_busy", busy, 1);
        resetn = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_quo", quo, 0);
        chk("midrst_rem", rem, 0);
        chk("midrst_dz", dz, 0);
        @(posedge clk); #3;
        resetn = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("rst_no_done", seen, 0);

        // Release just before a falling edge so the start lands on the first rising edge.
        @(posedge clk); #1;
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        run_op(32'd1000, 32'd33, q, r, z, lat, bc, bd);
        chk("postrst_q", q, 30);
        chk("postrst_r", r, 10);
        chk("postrst_dz", z, 0);
        chk("postrst_lat", lat, 16);

        fork
            random32(2500);
            random8(7500);
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
